// File: rtl/bch_decode_sequencer.sv
// Control sequencer for a BCH decoder: syndrome intake, per-channel Berlekamp solve, Chien output.
// Optional synchronous abort port enabled by defining BCH_SEQ_FLUSH_EN.
module bch_decode_sequencer #(
   parameter int N         = 15,
   parameter int K         = 5,
   parameter int T         = 3,
   parameter int ITERATION = 3,
   parameter int CHANNELS  = 1,
   localparam int IW = ($clog2(T + 1) > 0) ? $clog2(T + 1) : 1,
   localparam int PW = ($clog2(ITERATION) > 0) ? $clog2(ITERATION) : 1,
   localparam int CW = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1
) (
   input  logic          clk,
   input  logic          reset,
`ifdef BCH_SEQ_FLUSH_EN
   input  logic          flush,
`endif
   input  logic          start,
   output logic          start_ready,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          syn_ce,
   input  logic          drnzero,
   output logic          bsel,
   output logic          bm_first,
   output logic          bm_last,
   output logic [IW-1:0] bm_iter,
   output logic [PW-1:0] bm_phase,
   output logic [CW-1:0] chan,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          chien_ce,
   output logic          out_last,
   output logic          busy
);

   localparam int SW = ($clog2(N) > 0) ? $clog2(N) : 1;
   localparam int BW = ($clog2(K) > 0) ? $clog2(K) : 1;
   localparam int LW = ($clog2(T + 2) > 0) ? $clog2(T + 2) : 1;

   typedef enum logic [1:0] {IDLE, SYN, SOLVE, OUT} state_t;

   state_t        state;
   logic [SW-1:0] sym;
   logic [BW-1:0] beat;
   logic [LW-1:0] l;
   logic          solving;
   logic          chan_last;
   logic          flush_act;

`ifdef BCH_SEQ_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   assign start_ready = (state == IDLE);
   assign in_ready    = (state == SYN);
   assign out_valid   = (state == OUT);
   assign busy        = (state != IDLE);
   assign solving     = (state == SOLVE);
   assign syn_ce      = in_valid && in_ready;
   assign chien_ce    = out_valid && out_ready;
   assign chan_last   = (chan == CW'(CHANNELS - 1));

   assign bm_first = solving && (bm_iter == '0) && (bm_phase == '0);
   assign bm_last  = solving && (bm_phase == PW'(ITERATION - 1));
   // The first cycle of a channel always takes the update branch when the discrepancy is nonzero.
   assign bsel     = solving && drnzero && ((LW'(bm_iter) >= l) || bm_first);
   assign out_last = out_valid && chan_last && (beat == BW'(K - 1));

   always_ff @(posedge clk) begin
      if (reset || (flush_act && state != IDLE)) begin
         state    <= IDLE;
         sym      <= '0;
         beat     <= '0;
         chan     <= '0;
         bm_iter  <= '0;
         bm_phase <= '0;
         l        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= SYN;
            end
            // Syndrome beats arrive interleaved: channel index runs fastest.
            SYN: begin
               if (syn_ce) begin
                  if (chan_last) begin
                     chan <= '0;
                     if (sym == SW'(N - 1)) begin
                        sym   <= '0;
                        state <= SOLVE;
                     end else begin
                        sym <= sym + 1'b1;
                     end
                  end else begin
                     chan <= chan + 1'b1;
                  end
               end
            end
            SOLVE: begin
               if (bm_first)
                  l <= LW'(bsel);
               else if (bm_last && bsel)
                  l <= LW'({bm_iter, 1'b1}) - l;
               if (bm_last) begin
                  bm_phase <= '0;
                  if (bm_iter == IW'(T - 1)) begin
                     bm_iter <= '0;
                     if (chan_last) begin
                        chan  <= '0;
                        state <= OUT;
                     end else begin
                        chan <= chan + 1'b1;
                     end
                  end else begin
                     bm_iter <= bm_iter + 1'b1;
                  end
               end else begin
                  bm_phase <= bm_phase + 1'b1;
               end
            end
            OUT: begin
               if (chien_ce) begin
                  if (beat == BW'(K - 1)) begin
                     beat <= '0;
                     if (chan_last) begin
                        chan  <= '0;
                        state <= IDLE;
                     end else begin
                        chan <= chan + 1'b1;
                     end
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bch_decode_sequencer.sv
// Directed bench for bch_decode_sequencer: default instance plus a two-channel instance.
module tb_bch_decode_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic       reset, start, in_valid, drnzero, out_ready, flush;
   logic       start_ready, in_ready, syn_ce, bsel, bm_first, bm_last;
   logic [1:0] bm_iter, bm_phase;
   logic [0:0] chan;
   logic       out_valid, chien_ce, out_last, busy;

   logic       start2, in_valid2, drnzero2, out_ready2, flush2;
   logic       start_ready2, in_ready2, syn_ce2, bsel2, bm_first2, bm_last2;
   logic [1:0] bm_iter2, bm_phase2;
   logic [0:0] chan2;
   logic       out_valid2, chien_ce2, out_last2, busy2;

   wire solve1 = busy && !in_ready && !out_valid;
   wire solve2 = busy2 && !in_ready2 && !out_valid2;

   bch_decode_sequencer u_dut (
      .clk(clk), .reset(reset),
`ifdef BCH_SEQ_FLUSH_EN
      .flush(flush),
`endif
      .start(start), .start_ready(start_ready), .in_valid(in_valid), .in_ready(in_ready),
      .syn_ce(syn_ce), .drnzero(drnzero), .bsel(bsel), .bm_first(bm_first), .bm_last(bm_last),
      .bm_iter(bm_iter), .bm_phase(bm_phase), .chan(chan), .out_valid(out_valid),
      .out_ready(out_ready), .chien_ce(chien_ce), .out_last(out_last), .busy(busy)
   );

   bch_decode_sequencer #(.CHANNELS(2)) u_dut2 (
      .clk(clk), .reset(reset),
`ifdef BCH_SEQ_FLUSH_EN
      .flush(flush2),
`endif
      .start(start2), .start_ready(start_ready2), .in_valid(in_valid2), .in_ready(in_ready2),
      .syn_ce(syn_ce2), .drnzero(drnzero2), .bsel(bsel2), .bm_first(bm_first2), .bm_last(bm_last2),
      .bm_iter(bm_iter2), .bm_phase(bm_phase2), .chan(chan2), .out_valid(out_valid2),
      .out_ready(out_ready2), .chien_ce(chien_ce2), .out_last(out_last2), .busy(busy2)
   );

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(start_ready && !busy) && n < 200) begin
         @(negedge clk);
         start = 0; #1;
         n++;
      end
      tests++;
      if (!(start_ready && !busy)) begin
         fails++;
         $display("FAIL %s idle timeout: start_ready=%b busy=%b want 1 0", name, start_ready, busy);
      end
   endtask

   task automatic test_reset();
      logic [9:0] obs;
      logic [6:0] cnt;
      reset = 1; start = 1;
      repeat (3) @(negedge clk);
      reset = 0; start = 0; #1;
      obs = {start_ready, busy, in_ready, out_valid, out_last, syn_ce, chien_ce, bsel, bm_first, bm_last};
      tests++;
      if (obs !== 10'b1000000000) begin
         fails++; $display("FAIL reset outputs: got %b want %b", obs, 10'b1000000000);
      end
      cnt = {chan, bm_iter, bm_phase, u_dut.l};
      tests++;
      if (cnt !== 7'd0) begin
         fails++; $display("FAIL reset counters: got %b want 0", cnt);
      end
   endtask

   task automatic test_nominal();
      logic [7:0] obs, exp;
      for (int c = 0; c <= 32; c++) begin
         @(negedge clk);
         start = (c == 0); in_valid = 1; out_ready = 1; drnzero = 0;
         #1;
         obs = {syn_ce, solve1, out_valid, out_last, start_ready, bm_first, bm_last, chien_ce};
         exp = {c >= 1 && c <= 15, c >= 16 && c <= 24, c >= 25 && c <= 29, c == 29,
                c == 0 || c >= 30, c == 16, c == 18 || c == 21 || c == 24, c >= 25 && c <= 29};
         tests++;
         if (obs !== exp) begin
            fails++; $display("FAIL nominal cyc %0d: got %b want %b", c, obs, exp);
         end
      end
      start = 0;
   endtask

   task automatic test_stall();
      int ce_cnt = 0, first_solve = -1;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         start = (c == 0); in_valid = !(c >= 5 && c <= 8); out_ready = 1; drnzero = 0;
         #1;
         if (syn_ce) ce_cnt++;
         if (solve1 && first_solve < 0) first_solve = c;
         if (c == 6) begin
            tests++;
            if (syn_ce !== 1'b0 || in_ready !== 1'b1) begin
               fails++; $display("FAIL stall hold: syn_ce=%b in_ready=%b want 0 1", syn_ce, in_ready);
            end
         end
      end
      tests++;
      if (first_solve != 20) begin
         fails++; $display("FAIL stall solve start: got %0d want 20", first_solve);
      end
      tests++;
      if (ce_cnt != 15) begin
         fails++; $display("FAIL stall syn_ce count: got %0d want 15", ce_cnt);
      end
      wait_idle("stall");
   endtask

   task automatic test_drnzero();
      for (int c = 0; c <= 34; c++) begin
         @(negedge clk);
         start = (c == 0); in_valid = 1; out_ready = 1; drnzero = 1;
         #1;
         if (c == 10) begin
            tests++;
            if (bsel !== 1'b0) begin fails++; $display("FAIL bsel outside solve: got %b want 0", bsel); end
         end
         if (c == 16 || c == 17 || c == 19 || c == 22) begin
            tests++;
            if (bsel !== (c != 17)) begin
               fails++; $display("FAIL bsel cyc %0d: got %b want %b", c, bsel, c != 17);
            end
         end
         if (c == 19 || c == 22 || c == 25) begin
            tests++;
            if (u_dut.l !== 3'((c - 16) / 3)) begin
               fails++; $display("FAIL l cyc %0d: got %0d want %0d", c, u_dut.l, (c - 16) / 3);
            end
         end
      end
      drnzero = 0;
      wait_idle("drnzero");
   endtask

   task automatic test_reset_mid();
      int late = 0;
      for (int c = 0; c <= 35; c++) begin
         @(negedge clk);
         start = (c == 0); in_valid = 1; out_ready = 1; drnzero = 0; reset = (c == 20);
         #1;
         if (c == 21) begin
            tests++;
            if (start_ready !== 1'b1 || busy !== 1'b0) begin
               fails++; $display("FAIL midreset idle: start_ready=%b busy=%b want 1 0", start_ready, busy);
            end
         end
         if (c >= 21 && (out_valid || syn_ce || chien_ce)) late++;
      end
      tests++;
      if (late != 0) begin fails++; $display("FAIL midreset activity: got %0d want 0", late); end
      @(negedge clk);
      reset = 1; start = 1;
      @(negedge clk);
      reset = 0; start = 0; #1;
      tests++;
      if (start_ready !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL reset over start: start_ready=%b busy=%b want 1 0", start_ready, busy);
      end
   endtask

   task automatic test_start_ignored();
      for (int c = 0; c <= 31; c++) begin
         @(negedge clk);
         start = (c <= 29); in_valid = 1; out_ready = 1; drnzero = 0;
         #1;
         if (c == 25 || c == 31) begin
            tests++;
            if (out_valid !== (c == 25) || start_ready !== (c == 31)) begin
               fails++; $display("FAIL start ignored cyc %0d: out_valid=%b start_ready=%b", c, out_valid, start_ready);
            end
         end
      end
      start = 0;
   endtask

   task automatic test_channels2();
      int solve_cnt = 0, solve_chan_err = 0, pulses = 0, drop_err = 0, out_chan_err = 0, last_err = 0;
      logic pending = 0, done = 0;
      for (int c = 0; c <= 200 && !done; c++) begin
         @(negedge clk);
         start2 = (c == 0); in_valid2 = 1; drnzero2 = 0; out_ready2 = (c % 2 == 1);
         #1;
         if (c == 2) begin
            tests++;
            if (chan2 !== 1'b1) begin fails++; $display("FAIL ch2 syn chan: got %b want 1", chan2); end
         end
         if (solve2) begin
            if (chan2 !== 1'((solve_cnt >= 9) ? 1 : 0)) solve_chan_err++;
            solve_cnt++;
         end
         if (pending && !out_valid2) drop_err++;
         if (chien_ce2) begin
            if (chan2 !== 1'(pulses / 5)) out_chan_err++;
            if (out_last2 !== (pulses == 9)) last_err++;
            pulses++;
         end
         pending = out_valid2 && !chien_ce2;
         if (c > 5 && start_ready2) done = 1;
      end
      tests++;
      if (!done) begin fails++; $display("FAIL ch2 completion: got 0 want 1"); end
      tests++;
      if (solve_cnt != 18) begin fails++; $display("FAIL ch2 solve cycles: got %0d want 18", solve_cnt); end
      tests++;
      if (solve_chan_err != 0) begin fails++; $display("FAIL ch2 solve chan errs: got %0d want 0", solve_chan_err); end
      tests++;
      if (pulses != 10) begin fails++; $display("FAIL ch2 chien_ce count: got %0d want 10", pulses); end
      tests++;
      if (drop_err != 0) begin fails++; $display("FAIL ch2 out_valid drops: got %0d want 0", drop_err); end
      tests++;
      if (out_chan_err != 0 || last_err != 0) begin
         fails++; $display("FAIL ch2 out order: chan errs %0d last errs %0d want 0 0", out_chan_err, last_err);
      end
   endtask

`ifdef BCH_SEQ_FLUSH_EN
   task automatic test_flush();
      int lasts = 0;
      for (int c = 0; c <= 35; c++) begin
         @(negedge clk);
         start = (c == 0); in_valid = 1; out_ready = 1; drnzero = 0; flush = (c == 26);
         #1;
         if (out_last) lasts++;
         if (c == 27) begin
            tests++;
            if (start_ready !== 1'b1 || busy !== 1'b0) begin
               fails++; $display("FAIL flush idle: start_ready=%b busy=%b want 1 0", start_ready, busy);
            end
         end
      end
      tests++;
      if (lasts != 0) begin fails++; $display("FAIL flush out_last seen: got %0d want 0", lasts); end
   endtask
`endif

   initial begin
      reset = 1; start = 0; in_valid = 0; drnzero = 0; out_ready = 0; flush = 0;
      start2 = 0; in_valid2 = 0; drnzero2 = 0; out_ready2 = 0; flush2 = 0;
      test_reset();
      test_nominal();
      test_stall();
      test_drnzero();
      test_reset_mid();
      test_start_ignored();
      test_channels2();
`ifdef BCH_SEQ_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
